// File: rtl/mdio_sched.sv
// Arbitrates host MDIO transactions against a periodic link-status poll and
// sequences each one onto a strobe/clear MDIO master with a timeout.
module mdio_sched #(
  parameter int         POLL_PERIOD = 1000000,
  parameter int         TIMEOUT     = 65535,
  parameter logic [4:0] POLL_REG    = 5'd1
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [4:0]  host_reg,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        host_err,
  input  logic        poll_en,
  output logic [15:0] link_status,
  output logic        link_chg,
  output logic        mdio_rd,
  output logic        mdio_wr,
  output logic [4:0]  mdio_reg,
  output logic [15:0] mdio_wdata,
  input  logic [15:0] mdio_rdata,
  input  logic        mdio_vld,
  input  logic        mdio_clr_rd,
  input  logic        mdio_clr_wr,
  input  logic        mdio_busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: host_req is a level held until the one-cycle host_ack; operands
  // are taken on the grant edge. Toward the MDIO master, mdio_rd/mdio_wr is a
  // level held until the matching mdio_clr_* is seen in WAIT; mdio_vld marks
  // read data in WAIT. Clears and vld arriving in any other state are ignored.

  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] timer_q;
  logic          poll_pend_q;
  logic          rr_poll_q;
  logic          owner_poll_q;
  logic          op_we_q;
  logic [4:0]    mdio_reg_q;
  logic [15:0]   mdio_wdata_q;
  logic          mdio_rd_q, mdio_wr_q;
  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_flag_q;
  logic [15:0]   rdata_cap_q;
  logic [15:0]   host_rdata_q;
  logic [15:0]   link_status_q;

  logic grant, grant_poll, clr_match, tmo_hit;

  assign clr_match = op_we_q ? mdio_clr_wr : mdio_clr_rd;
  assign tmo_hit   = (tmo_cnt_q == TMO_LAST);

  // State register
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and arbitration
  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    grant_poll = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!mdio_busy && (host_req || poll_pend_q)) begin
          grant      = 1'b1;
          grant_poll = poll_pend_q && (!host_req || rr_poll_q);
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (clr_match || tmo_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    host_ack  = (state_q == S_DONE) && !owner_poll_q;
    host_err  = (state_q == S_DONE) && !owner_poll_q && tmo_flag_q;
    link_chg  = (state_q == S_DONE) && owner_poll_q && !tmo_flag_q &&
                (rdata_cap_q != link_status_q);
    dbg_state = state_q;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      timer_q       <= '0;
      poll_pend_q   <= 1'b0;
      rr_poll_q     <= 1'b0;
      owner_poll_q  <= 1'b0;
      op_we_q       <= 1'b0;
      mdio_reg_q    <= '0;
      mdio_wdata_q  <= '0;
      mdio_rd_q     <= 1'b0;
      mdio_wr_q     <= 1'b0;
      tmo_cnt_q     <= '0;
      tmo_flag_q    <= 1'b0;
      rdata_cap_q   <= '0;
      host_rdata_q  <= '0;
      link_status_q <= '0;
    end else begin
      // A wrap on the same edge as a poll grant re-arms the single pending slot.
      if (!poll_en) begin
        timer_q     <= '0;
        poll_pend_q <= 1'b0;
      end else begin
        timer_q <= (timer_q == POLL_LAST) ? '0 : timer_q + 1'b1;
        if (timer_q == POLL_LAST)     poll_pend_q <= 1'b1;
        else if (grant && grant_poll) poll_pend_q <= 1'b0;
      end

      if (grant) begin
        owner_poll_q <= grant_poll;
        rr_poll_q    <= !grant_poll;
        op_we_q      <= grant_poll ? 1'b0 : host_we;
        mdio_reg_q   <= grant_poll ? POLL_REG : host_reg;
        if (!grant_poll) mdio_wdata_q <= host_wdata;
      end

      case (state_q)
        S_ISSUE: begin
          mdio_rd_q  <= !op_we_q;
          mdio_wr_q  <= op_we_q;
          tmo_cnt_q  <= '0;
          tmo_flag_q <= 1'b0;
        end
        S_WAIT: begin
          if (mdio_vld && !op_we_q) rdata_cap_q <= mdio_rdata;
          if (clr_match) begin
            mdio_rd_q <= 1'b0;
            mdio_wr_q <= 1'b0;
            if (!owner_poll_q && !op_we_q)
              host_rdata_q <= (mdio_vld ? mdio_rdata : rdata_cap_q);
          end else if (tmo_hit) begin
            mdio_rd_q  <= 1'b0;
            mdio_wr_q  <= 1'b0;
            tmo_flag_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (owner_poll_q && !tmo_flag_q) link_status_q <= rdata_cap_q;
        end
        default: ;
      endcase
    end
  end

  assign mdio_rd     = mdio_rd_q;
  assign mdio_wr     = mdio_wr_q;
  assign mdio_reg    = mdio_reg_q;
  assign mdio_wdata  = mdio_wdata_q;
  assign host_rdata  = host_rdata_q;
  assign link_status = link_status_q;

endmodule

// File: tb/tb_mdio_sched.sv
// Directed bench for mdio_sched: host read/write, polling with change pulses,
// round-robin alternation, timeout, ignored stray strobes and async reset.
module tb_mdio_sched;

  logic wb_clk, wb_rst;
  int   errors = 0;
  int   checks = 0;

  // Instance a: short poll period, generous timeout
  logic        a_host_req, a_host_we;
  logic [4:0]  a_host_reg;
  logic [15:0] a_host_wdata;
  logic        a_host_ack, a_host_err;
  logic [15:0] a_host_rdata;
  logic        a_poll_en;
  logic [15:0] a_link_status;
  logic        a_link_chg;
  logic        a_mdio_rd, a_mdio_wr;
  logic [4:0]  a_mdio_reg;
  logic [15:0] a_mdio_wdata, a_mdio_rdata;
  logic        a_mdio_vld, a_mdio_clr_rd, a_mdio_clr_wr, a_mdio_busy;
  logic [1:0]  a_dbg_state;

  // Instance b: short timeout
  logic        b_host_req, b_host_we;
  logic [4:0]  b_host_reg;
  logic [15:0] b_host_wdata;
  logic        b_host_ack, b_host_err;
  logic [15:0] b_host_rdata;
  logic        b_poll_en;
  logic [15:0] b_link_status;
  logic        b_link_chg;
  logic        b_mdio_rd, b_mdio_wr;
  logic [4:0]  b_mdio_reg;
  logic [15:0] b_mdio_wdata, b_mdio_rdata;
  logic        b_mdio_vld, b_mdio_clr_rd, b_mdio_clr_wr, b_mdio_busy;
  logic [1:0]  b_dbg_state;

  mdio_sched #(.POLL_PERIOD(100), .TIMEOUT(300), .POLL_REG(5'd1)) u_a (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .host_req(a_host_req), .host_we(a_host_we), .host_reg(a_host_reg),
    .host_wdata(a_host_wdata), .host_ack(a_host_ack), .host_rdata(a_host_rdata),
    .host_err(a_host_err), .poll_en(a_poll_en), .link_status(a_link_status),
    .link_chg(a_link_chg), .mdio_rd(a_mdio_rd), .mdio_wr(a_mdio_wr),
    .mdio_reg(a_mdio_reg), .mdio_wdata(a_mdio_wdata), .mdio_rdata(a_mdio_rdata),
    .mdio_vld(a_mdio_vld), .mdio_clr_rd(a_mdio_clr_rd), .mdio_clr_wr(a_mdio_clr_wr),
    .mdio_busy(a_mdio_busy), .dbg_state(a_dbg_state)
  );

  mdio_sched #(.POLL_PERIOD(100), .TIMEOUT(50), .POLL_REG(5'd1)) u_b (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .host_req(b_host_req), .host_we(b_host_we), .host_reg(b_host_reg),
    .host_wdata(b_host_wdata), .host_ack(b_host_ack), .host_rdata(b_host_rdata),
    .host_err(b_host_err), .poll_en(b_poll_en), .link_status(b_link_status),
    .link_chg(b_link_chg), .mdio_rd(b_mdio_rd), .mdio_wr(b_mdio_wr),
    .mdio_reg(b_mdio_reg), .mdio_wdata(b_mdio_wdata), .mdio_rdata(b_mdio_rdata),
    .mdio_vld(b_mdio_vld), .mdio_clr_rd(b_mdio_clr_rd), .mdio_clr_wr(b_mdio_clr_wr),
    .mdio_busy(b_mdio_busy), .dbg_state(b_dbg_state)
  );

  // Clock and watchdog
  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe_a(output int n);
    n = 0;
    while (!(a_mdio_rd || a_mdio_wr) && n < 500) begin
      @(negedge wb_clk);
      n++;
    end
    chk("a_strobe_seen", {31'd0, a_mdio_rd | a_mdio_wr}, 32'd1);
  endtask

  // Holds the strobe for 'delay' cycles, then vld (reads) and the matching clr.
  // Returns on the negedge after the clr-observing edge (the DONE cycle).
  task automatic respond_a(input int delay, input logic is_wr, input logic [15:0] data);
    int held = 0;
    for (int i = 0; i < delay; i++) begin
      @(negedge wb_clk);
      if (a_mdio_rd || a_mdio_wr) held++;
    end
    chk("a_strobe_hold", held, delay);
    if (!is_wr) begin
      a_mdio_vld = 1'b1;
      a_mdio_rdata = data;
      @(negedge wb_clk);
      a_mdio_vld = 1'b0;
      a_mdio_rdata = 16'hDEAD;
    end
    if (is_wr) a_mdio_clr_wr = 1'b1;
    else       a_mdio_clr_rd = 1'b1;
    @(negedge wb_clk);
    a_mdio_clr_rd = 1'b0;
    a_mdio_clr_wr = 1'b0;
    chk("a_strobe_drop", {31'd0, a_mdio_rd | a_mdio_wr}, 32'd0);
  endtask

  initial begin
    int n, cnt, guard;
    logic ack_seen;
    logic is_poll;

    wb_rst = 1'b1;
    a_host_req = 0; a_host_we = 0; a_host_reg = 0; a_host_wdata = 0; a_poll_en = 0;
    a_mdio_rdata = 0; a_mdio_vld = 0; a_mdio_clr_rd = 0; a_mdio_clr_wr = 0; a_mdio_busy = 0;
    b_host_req = 0; b_host_we = 0; b_host_reg = 0; b_host_wdata = 0; b_poll_en = 0;
    b_mdio_rdata = 0; b_mdio_vld = 0; b_mdio_clr_rd = 0; b_mdio_clr_wr = 0; b_mdio_busy = 0;

    // Reset values
    repeat (3) @(negedge wb_clk);
    chk("rst_state", {30'd0, a_dbg_state}, 32'd0);
    chk("rst_strobes", {30'd0, a_mdio_rd, a_mdio_wr}, 32'd0);
    chk("rst_ack_err", {30'd0, a_host_ack, a_host_err}, 32'd0);
    chk("rst_rdata", {16'd0, a_host_rdata}, 32'd0);
    chk("rst_link", {15'd0, a_link_status, a_link_chg}, 32'd0);
    chk("rst_operands", {11'd0, a_mdio_reg, a_mdio_wdata}, 32'd0);
    wb_rst = 1'b0;
    repeat (2) @(negedge wb_clk);

    // Host read of reg 2, data after ~200 cycles; checks grant latency too
    a_host_req = 1; a_host_we = 0; a_host_reg = 5'd2; a_host_wdata = 16'h5555;
    @(negedge wb_clk);
    chk("rd_issue_state", {30'd0, a_dbg_state}, 32'd1);
    chk("rd_no_strobe_yet", {31'd0, a_mdio_rd}, 32'd0);
    @(negedge wb_clk);
    chk("rd_strobe", {30'd0, a_mdio_rd, a_mdio_wr}, 32'd2);
    chk("rd_reg", {27'd0, a_mdio_reg}, 32'd2);
    chk("rd_wait_state", {30'd0, a_dbg_state}, 32'd2);
    respond_a(198, 1'b0, 16'h0141);
    chk("rd_ack", {31'd0, a_host_ack}, 32'd1);
    chk("rd_err", {31'd0, a_host_err}, 32'd0);
    chk("rd_rdata", {16'd0, a_host_rdata}, 32'h0141);
    a_host_req = 0;
    @(negedge wb_clk);
    chk("rd_ack_one_cycle", {31'd0, a_host_ack}, 32'd0);
    chk("rd_back_idle", {30'd0, a_dbg_state}, 32'd0);

    // Host write reg 0 = 0x8000; request dropped mid-transaction
    a_host_req = 1; a_host_we = 1; a_host_reg = 5'd0; a_host_wdata = 16'h8000;
    wait_strobe_a(n);
    chk("wr_latency", n, 2);
    chk("wr_strobe", {30'd0, a_mdio_rd, a_mdio_wr}, 32'd1);
    chk("wr_operands", {11'd0, a_mdio_reg, a_mdio_wdata}, 32'h0008000);
    a_host_req = 0;
    respond_a(4, 1'b1, 16'h0000);
    chk("wr_ack", {30'd0, a_host_ack, a_host_err}, 32'd2);
    chk("wr_rdata_kept", {16'd0, a_host_rdata}, 32'h0141);
    chk("wr_link_kept", {15'd0, a_link_status, a_link_chg}, 32'd0);
    @(negedge wb_clk);
    chk("wr_ack_one_cycle", {31'd0, a_host_ack}, 32'd0);

    // Polling: change, change, repeat value
    a_poll_en = 1;
    wait_strobe_a(n);
    chk("p1_op", {26'd0, a_mdio_rd, a_mdio_wr, a_mdio_reg}, 32'h41);
    respond_a(3, 1'b0, 16'h796D);
    chk("p1_chg", {30'd0, a_link_chg, a_host_ack}, 32'd2);
    @(negedge wb_clk);
    chk("p1_status", {15'd0, a_link_status, a_link_chg}, {15'd0, 16'h796D, 1'b0});
    wait_strobe_a(n);
    respond_a(5, 1'b0, 16'h7969);
    chk("p2_chg", {31'd0, a_link_chg}, 32'd1);
    @(negedge wb_clk);
    chk("p2_status", {16'd0, a_link_status}, 32'h7969);
    wait_strobe_a(n);
    respond_a(5, 1'b0, 16'h7969);
    chk("p3_no_chg", {31'd0, a_link_chg}, 32'd0);
    @(negedge wb_clk);
    chk("p3_status", {16'd0, a_link_status}, 32'h7969);

    // Host held continuously while polls keep pending: host, poll, host, poll
    a_host_req = 1; a_host_we = 0; a_host_reg = 5'd3;
    for (int k = 0; k < 4; k++) begin
      wait_strobe_a(n);
      is_poll = (a_mdio_reg == 5'd1);
      chk("rr_owner", {31'd0, is_poll}, k % 2);
      respond_a(110, 1'b0, is_poll ? 16'h7969 : (16'h1230 + 16'(k)));
      chk("rr_ack", {31'd0, a_host_ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
      if (!is_poll) chk("rr_rdata", {16'd0, a_host_rdata}, 32'h1230 + k);
      if (k == 3) begin
        a_host_req = 0;
        a_poll_en = 0;
      end
    end
    repeat (3) @(negedge wb_clk);
    chk("rr_quiet", {29'd0, a_dbg_state, a_mdio_rd}, 32'd0);

    // Instance b: stray clr/vld in IDLE, busy blocking, then timeout
    b_mdio_clr_rd = 1; b_mdio_clr_wr = 1; b_mdio_vld = 1; b_mdio_rdata = 16'hABCD;
    @(negedge wb_clk);
    b_mdio_clr_rd = 0; b_mdio_clr_wr = 0; b_mdio_vld = 0;
    chk("b_stray_ignored", {29'd0, b_dbg_state, b_host_ack}, 32'd0);
    b_mdio_busy = 1;
    b_host_req = 1; b_host_we = 0; b_host_reg = 5'd4; b_host_wdata = 16'h1111;
    repeat (3) @(negedge wb_clk);
    chk("b_busy_blocks", {29'd0, b_dbg_state, b_mdio_rd}, 32'd0);
    b_mdio_busy = 0;
    n = 0;
    while (!b_mdio_rd && n < 20) begin
      @(negedge wb_clk);
      n++;
    end
    chk("b_latency", n, 2);
    chk("b_operands", {10'd0, b_mdio_wr, b_mdio_reg, b_mdio_wdata}, 32'h0041111);
    cnt = 0; guard = 0;
    while (b_mdio_rd && guard < 200) begin
      cnt++;
      @(negedge wb_clk);
      guard++;
    end
    chk("tmo_strobe_cycles", cnt, 50);
    chk("tmo_ack_err", {30'd0, b_host_ack, b_host_err}, 32'd3);
    chk("tmo_rdata_kept", {16'd0, b_host_rdata}, 32'd0);
    chk("tmo_link", {15'd0, b_link_status, b_link_chg}, 32'd0);
    b_host_req = 0;
    @(negedge wb_clk);
    chk("tmo_idle", {29'd0, b_dbg_state, b_host_ack}, 32'd0);

    // Reset pulsed during WAIT on instance a
    a_host_req = 1; a_host_we = 0; a_host_reg = 5'd5;
    wait_strobe_a(n);
    repeat (3) @(negedge wb_clk);
    wb_rst = 1;
    a_host_req = 0;
    #1;
    chk("rst_wait_strobe", {30'd0, a_mdio_rd, a_mdio_wr}, 32'd0);
    chk("rst_wait_state", {30'd0, a_dbg_state}, 32'd0);
    chk("rst_wait_outs", {14'd0, a_host_ack, a_host_err, a_host_rdata}, 32'd0);
    chk("rst_wait_link", {11'd0, a_link_status, a_mdio_reg}, 32'd0);
    @(negedge wb_clk);
    wb_rst = 0;
    ack_seen = 0;
    repeat (30) begin
      @(negedge wb_clk);
      if (a_host_ack) ack_seen = 1;
    end
    chk("rst_no_late_ack", {31'd0, ack_seen}, 32'd0);
    chk("rst_stays_idle", {30'd0, a_dbg_state}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
